// File: rtl/wl_pulse_sequencer.sv
// Word-line pulse sequencer: per-row precharge -> WL/WLB pulse -> recovery,
// with optional row burst, CAM search mode and cs-driven abort.
module wl_pulse_sequencer #(
   parameter int unsigned NUM_ROWS = 4,
   parameter int unsigned ADDR_W   = 2,
   parameter int unsigned PW_W     = 4,
   parameter int unsigned PRE_CYC  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cs,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [NUM_ROWS-1:0] data,
   input  logic [ADDR_W:0]     burst_len,
   input  logic [PW_W-1:0]     pulse_cycles,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic                precharge,
   output logic [ADDR_W-1:0]   row_idx,
   output logic [NUM_ROWS-1:0] WL,
   output logic [NUM_ROWS-1:0] WLB
);

   localparam int unsigned BL_W  = ADDR_W + 1;
   localparam int unsigned PRE_W = $clog2(PRE_CYC + 1);
   localparam int unsigned CNT_W = (PW_W > PRE_W) ? PW_W : PRE_W;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_REC, S_DONE} state_t;

   state_t              r_state, w_state;
   logic [1:0]          r_mode, w_mode;
   logic [NUM_ROWS-1:0] r_data, w_data;
   logic [BL_W-1:0]     r_rows, w_rows;
   logic [PW_W-1:0]     r_pw, w_pw;
   logic [CNT_W-1:0]    r_cnt, w_cnt;
   logic [ADDR_W-1:0]   r_row, w_row;
   logic                r_busy, w_busy;
   logic                r_done, w_done;
   logic                r_aborted, w_aborted;
   logic                r_precharge, w_precharge;
   logic [NUM_ROWS-1:0] r_wl, w_wl;
   logic [NUM_ROWS-1:0] r_wlb, w_wlb;
   logic [NUM_ROWS-1:0] w_onehot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_mode      <= '0;
         r_data      <= '0;
         r_rows      <= '0;
         r_pw        <= '0;
         r_cnt       <= '0;
         r_row       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_aborted   <= 1'b0;
         r_precharge <= 1'b0;
         r_wl        <= '0;
         r_wlb       <= '0;
      end else begin
         r_state     <= w_state;
         r_mode      <= w_mode;
         r_data      <= w_data;
         r_rows      <= w_rows;
         r_pw        <= w_pw;
         r_cnt       <= w_cnt;
         r_row       <= w_row;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_aborted   <= w_aborted;
         r_precharge <= w_precharge;
         r_wl        <= w_wl;
         r_wlb       <= w_wlb;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_mode      = r_mode;
      w_data      = r_data;
      w_rows      = r_rows;
      w_pw        = r_pw;
      w_cnt       = r_cnt;
      w_row       = r_row;
      w_aborted   = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_precharge = 1'b0;
      w_wl        = '0;
      w_wlb       = '0;
      w_onehot    = '0;

      unique case (r_state)
         S_IDLE: begin
            if (start && cs) begin
               w_state = S_PRE;
               w_mode  = mode;
               w_data  = data;
               w_row   = addr;
               w_pw    = (pulse_cycles == '0) ? PW_W'(1) : pulse_cycles;
               w_cnt   = CNT_W'(PRE_CYC - 1);
               // CAM search is always a single pass regardless of burst_len
               if (mode == 2'b11 || burst_len == '0)
                  w_rows = BL_W'(1);
               else if (burst_len > BL_W'(NUM_ROWS))
                  w_rows = BL_W'(NUM_ROWS);
               else
                  w_rows = burst_len;
            end
         end
         S_PRE: begin
            if (r_cnt == '0) begin
               w_state = S_ACT;
               w_cnt   = CNT_W'(r_pw - PW_W'(1));
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         S_ACT: begin
            if (r_cnt == '0) w_state = S_REC;
            else             w_cnt   = r_cnt - CNT_W'(1);
         end
         S_REC: begin
            if (r_rows > BL_W'(1)) begin
               w_state = S_PRE;
               w_rows  = r_rows - BL_W'(1);
               w_row   = r_row + ADDR_W'(1);
               w_cnt   = CNT_W'(PRE_CYC - 1);
            end else begin
               w_state = S_DONE;
            end
         end
         S_DONE:  w_state = S_IDLE;
         default: w_state = S_IDLE;
      endcase

      // Dropping cs mid-op wins over any transition and leaves row_idx where it was
      if (!cs && (r_state == S_PRE || r_state == S_ACT || r_state == S_REC)) begin
         w_state   = S_IDLE;
         w_row     = r_row;
         w_aborted = 1'b1;
      end

      w_busy      = (w_state == S_PRE) || (w_state == S_ACT) || (w_state == S_REC);
      w_precharge = (w_state == S_PRE);
      w_done      = (w_state == S_DONE);
      w_onehot    = NUM_ROWS'(1) << w_row;
      if (w_state == S_ACT) begin
         unique case (w_mode)
            2'b00:   begin w_wl = w_onehot; w_wlb = w_onehot; end
            2'b01:   begin w_wl = w_onehot; w_wlb = '0;       end
            2'b10:   begin w_wl = '0;       w_wlb = w_onehot; end
            default: begin w_wl = w_data;   w_wlb = ~w_data;  end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign aborted   = r_aborted;
   assign precharge = r_precharge;
   assign row_idx   = r_row;
   assign WL        = r_wl;
   assign WLB       = r_wlb;

endmodule
